mcmc_global_control_unit: RTL and testbench
===========================================

# mcmc_global_control_unit

Top-level sequencer of the MCMC constraint solver. Drives the 8-bit global phase code (0 idle, 1 setup, 2 probabilistic, 3 stochastic, 4 probability adjustment, 5 checker, 6 finish) that every search sub-unit decodes. Collects their ready/done handshakes and picks the probabilistic or stochastic move each iteration by comparing a random sample against a probability threshold. Enforces an iteration limit and a per-phase watchdog.

## Interface
- MAXIMUM_BIT_WIDTH_OF_ITERATIONS, 16: width of the iteration counter.
- MAXIMUM_ITERATIONS, 1000: iterations before giving up.
- PROBABILITY_WIDTH, 8: width of random sample and threshold.
- PHASE_TIMEOUT_CYCLES, 4096: max cycles in any waiting phase.
- in_clk  input  1  single clock; all state changes on its rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_start  input  1  level; a rising edge starts or restarts a solve.
- in_setup_done  input  1  setup loaders finished.
- in_probabilistic_ready  input  1  probabilistic unit result valid.
- in_stochastic_ready  input  1  stochastic unit result valid (held while phase stays 3).
- in_adjust_done  input  1  probability adjustment finished.
- in_checker_done  input  1  checker result valid.
- in_all_satisfied  input  1  checker verdict, sampled only with in_checker_done.
- in_random  input  PROBABILITY_WIDTH  uniform random sample.
- in_stochastic_probability  input  PROBABILITY_WIDTH  threshold for choosing stochastic.
- out_current_state  output  8  registered phase code; reset 0.
- out_iteration_count  output  MAXIMUM_BIT_WIDTH_OF_ITERATIONS  completed iterations; reset 0.
- out_solved  output  1  finished with all clauses satisfied; reset 0.
- out_iteration_limit  output  1  finished because the iteration limit was hit; reset 0.
- out_watchdog_error  output  1  finished because a phase timed out; reset 0.
- out_finish  output  1  high exactly while the phase is 6; reset 0.

## Operation
- IDLE(0): wait for a rising edge on in_start (registered edge detect). Then go to SETUP.
  - Clear the iteration count and all three status flags.
- SETUP(1): wait for in_setup_done, then go to CHECKER (the initial assignment is checked first).
- CHECKER(5): on in_checker_done:
  - in_all_satisfied=1: go to FINISH and set out_solved.
  - Otherwise, if the iteration count equals MAXIMUM_ITERATIONS: go to FINISH and set out_iteration_limit.
  - Otherwise increment the iteration count and branch. in_random < in_stochastic_probability (unsigned) goes to STOCHASTIC(3); else PROBABILISTIC(2).
- PROBABILISTIC(2) / STOCHASTIC(3): wait for the matching ready, then go to ADJUST(4). The other unit's ready is ignored.
- ADJUST(4): wait for in_adjust_done, then go to CHECKER.
- FINISH(6): hold the phase and status flags. A new in_start rising edge goes to SETUP and clears the count and flags.
- Codes 7–255 are never driven. If the internal state register ever decodes to an illegal value, it returns to IDLE.

## Timing
- Each phase change is registered and visible one cycle after the qualifying input is sampled high.
- Sub-units update on the falling edge. A phase code is therefore seen by them half a cycle after it changes.
- Blanking rule: for the first cycle after entering phases 1, 2, 3, 4 or 5, all done/ready inputs are ignored. This prevents a stale ready from the previous visit of the same unit from being taken.
  - Minimum dwell per phase is 2 cycles.
- Minimum iteration (5→3→4→5) is 6 cycles.
- Watchdog:
  - A cycle counter clears on every phase entry.
  - It counts in phases 1–5.
  - On reaching PHASE_TIMEOUT_CYCLES−1 without the qualifying input, the next state is FINISH and out_watchdog_error is set.
  - If the qualifying input and the timeout occur in the same cycle, the handshake wins.
- The iteration count saturates at MAXIMUM_ITERATIONS and never wraps.
- in_reset has priority over everything. It takes effect at the next rising edge: all outputs return to their reset values and the phase returns to 0, including mid-phase. in_start held high through reset does not start a solve; a fresh rising edge is required.

## Structure
- Shared package mcmc_pkg:
  - Phase-code constants IDLE=0, SETUP=1, PROBABILISTIC=2, STOCHASTIC=3, PROBABILITY_ADJUSTMENT=4, CHECKER=5, FINISH=6.
  - Phase-code width 8.
  - These constants are reused by every sub-unit decoder.
- Sub-module mcmc_phase_watchdog holds the timeout counter. Interface: clear on phase entry, enable, timeout output.

## Test plan
- Immediate solve: start pulse, setup_done at cycle 3, checker_done with all_satisfied=1. Required: phases 0→1→5→6, out_solved=1, out_iteration_count=0, out_finish=1.
- Branch selection: in_stochastic_probability=128, in_random=50 then 200. Required: first iteration enters phase 3, second enters phase 2, count=2.
- Stale ready: in_stochastic_ready held high on entry to phase 3. Required: no transition in the blanking cycle; moves to phase 4 on the second cycle.
- Iteration limit: MAXIMUM_ITERATIONS=3 and the checker never satisfied. Required: FINISH with out_iteration_limit=1 and count=3.
- Watchdog: PHASE_TIMEOUT_CYCLES=16 and in_adjust_done never asserted. Required: FINISH after 16 cycles in phase 4, out_watchdog_error=1. Same run with done asserted at cycle 15: normal transition to phase 5 and no error.
- Reset mid-operation: in_reset asserted in phase 3 with start held high. Required: phase 0 and all outputs 0 next cycle; no restart until in_start toggles.

Source files
------------

// File: rtl/mcmc_pkg.sv
// Shared phase codes for the MCMC constraint solver. Every sub-unit decodes
// the 8-bit global phase against these constants.
package mcmc_pkg;

    localparam int PHASE_WIDTH = 8;

    typedef enum logic [PHASE_WIDTH-1:0] {
        IDLE                   = 8'd0,
        SETUP                  = 8'd1,
        PROBABILISTIC          = 8'd2,
        STOCHASTIC             = 8'd3,
        PROBABILITY_ADJUSTMENT = 8'd4,
        CHECKER                = 8'd5,
        FINISH                 = 8'd6
    } phase_e;

    // Phases in which the sequencer waits on a sub-unit handshake and the
    // watchdog is allowed to run.
    function automatic logic is_wait_phase(phase_e p);
        return (p >= SETUP) && (p <= CHECKER);
    endfunction

endpackage

// File: rtl/mcmc_phase_watchdog.sv
// Per-phase cycle counter. Cleared on every phase entry, counts while
// enabled and flags a timeout once it reaches TIMEOUT_CYCLES-1.
module mcmc_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then count up while enabled, holding at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mcmc_global_control_unit.sv
// Top-level sequencer of the MCMC constraint solver: drives the global phase
// code, collects sub-unit handshakes, chooses the move type each iteration
// and stops on success, iteration limit or phase timeout.
//
// Handshake semantics: each done/ready input is a level that qualifies the
// current phase when sampled high at a rising edge, except during the first
// cycle after a phase entry, where all of them are ignored so a ready still
// held from the previous visit of the same unit cannot be taken twice.
module mcmc_global_control_unit
    import mcmc_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_ITERATIONS = 16,
    parameter int MAXIMUM_ITERATIONS              = 1000,
    parameter int PROBABILITY_WIDTH               = 8,
    parameter int PHASE_TIMEOUT_CYCLES            = 4096
) (
    input  logic                                       in_clk,
    input  logic                                       in_reset,
    input  logic                                       in_start,
    input  logic                                       in_setup_done,
    input  logic                                       in_probabilistic_ready,
    input  logic                                       in_stochastic_ready,
    input  logic                                       in_adjust_done,
    input  logic                                       in_checker_done,
    input  logic                                       in_all_satisfied,
    input  logic [PROBABILITY_WIDTH-1:0]               in_random,
    input  logic [PROBABILITY_WIDTH-1:0]               in_stochastic_probability,
    output logic [PHASE_WIDTH-1:0]                     out_current_state,
    output logic [MAXIMUM_BIT_WIDTH_OF_ITERATIONS-1:0] out_iteration_count,
    output logic                                       out_solved,
    output logic                                       out_iteration_limit,
    output logic                                       out_watchdog_error,
    output logic                                       out_finish
);

    localparam int IW = MAXIMUM_BIT_WIDTH_OF_ITERATIONS;
    localparam logic [IW-1:0] MAX_ITER = IW'(MAXIMUM_ITERATIONS);

    phase_e          state_q, state_d;
    logic [IW-1:0]   count_q, count_d;
    logic            solved_q, solved_d;
    logic            limit_q, limit_d;
    logic            wd_q, wd_d;
    logic            start_q;
    logic            blank_q;
    logic            start_rise;
    logic            phase_change;
    logic            timeout;

    assign start_rise   = in_start && !start_q;
    assign phase_change = (state_d != state_q);

    mcmc_phase_watchdog #(
        .TIMEOUT_CYCLES(PHASE_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (in_clk),
        .rst_i     (in_reset),
        .clear_i   (phase_change),
        .enable_i  (is_wait_phase(state_q)),
        .timeout_o (timeout)
    );

    // Next phase and status: handshake first, timeout only if no handshake.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        solved_d = solved_q;
        limit_d  = limit_q;
        wd_d     = wd_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start_rise) begin
                    state_d  = SETUP;
                    count_d  = '0;
                    solved_d = 1'b0;
                    limit_d  = 1'b0;
                    wd_d     = 1'b0;
                end
            end
            SETUP: begin
                if (!blank_q && in_setup_done) begin
                    state_d = CHECKER;
                end else if (timeout) begin
                    state_d = FINISH;
                    wd_d    = 1'b1;
                end
            end
            CHECKER: begin
                if (!blank_q && in_checker_done) begin
                    if (in_all_satisfied) begin
                        state_d  = FINISH;
                        solved_d = 1'b1;
                    end else if (count_q >= MAX_ITER) begin
                        state_d = FINISH;
                        limit_d = 1'b1;
                    end else begin
                        count_d = count_q + IW'(1);
                        state_d = (in_random < in_stochastic_probability) ? STOCHASTIC
                                                                          : PROBABILISTIC;
                    end
                end else if (timeout) begin
                    state_d = FINISH;
                    wd_d    = 1'b1;
                end
            end
            PROBABILISTIC: begin
                if (!blank_q && in_probabilistic_ready) begin
                    state_d = PROBABILITY_ADJUSTMENT;
                end else if (timeout) begin
                    state_d = FINISH;
                    wd_d    = 1'b1;
                end
            end
            STOCHASTIC: begin
                if (!blank_q && in_stochastic_ready) begin
                    state_d = PROBABILITY_ADJUSTMENT;
                end else if (timeout) begin
                    state_d = FINISH;
                    wd_d    = 1'b1;
                end
            end
            PROBABILITY_ADJUSTMENT: begin
                if (!blank_q && in_adjust_done) begin
                    state_d = CHECKER;
                end else if (timeout) begin
                    state_d = FINISH;
                    wd_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, status and blanking registers; start is tracked even in reset so
    // a level held through reset never looks like a fresh edge.
    always_ff @(posedge in_clk) begin
        start_q <= in_start;
        if (in_reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            solved_q <= 1'b0;
            limit_q  <= 1'b0;
            wd_q     <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            solved_q <= solved_d;
            limit_q  <= limit_d;
            wd_q     <= wd_d;
            blank_q  <= phase_change;
        end
    end

    assign out_current_state   = state_q;
    assign out_iteration_count = count_q;
    assign out_solved          = solved_q;
    assign out_iteration_limit = limit_q;
    assign out_watchdog_error  = wd_q;
    assign out_finish          = (state_q == FINISH);

endmodule

// File: tb/tb_mcmc_global_control_unit.sv
// Bench for the MCMC global sequencer. A driver plays the sub-units and a
// reference model predicts every phase change (cycle, phase, count, flags);
// a monitor pops and compares whenever the phase output changes.
module tb_mcmc_global_control_unit;

    localparam int MAX_IT = 3;
    localparam int TMO    = 16;
    localparam int W      = 59;   // {cycle[31:0], phase[7:0], count[15:0], solved, limit, wd}

    logic        in_clk = 1'b0;
    logic        in_reset;
    logic        in_start;
    logic        in_setup_done;
    logic        in_probabilistic_ready;
    logic        in_stochastic_ready;
    logic        in_adjust_done;
    logic        in_checker_done;
    logic        in_all_satisfied;
    logic [7:0]  in_random;
    logic [7:0]  in_stochastic_probability;
    logic [7:0]  out_current_state;
    logic [15:0] out_iteration_count;
    logic        out_solved;
    logic        out_iteration_limit;
    logic        out_watchdog_error;
    logic        out_finish;

    mcmc_global_control_unit #(
        .MAXIMUM_BIT_WIDTH_OF_ITERATIONS(16),
        .MAXIMUM_ITERATIONS             (MAX_IT),
        .PROBABILITY_WIDTH              (8),
        .PHASE_TIMEOUT_CYCLES           (TMO)
    ) dut (
        .in_clk                    (in_clk),
        .in_reset                  (in_reset),
        .in_start                  (in_start),
        .in_setup_done             (in_setup_done),
        .in_probabilistic_ready    (in_probabilistic_ready),
        .in_stochastic_ready       (in_stochastic_ready),
        .in_adjust_done            (in_adjust_done),
        .in_checker_done           (in_checker_done),
        .in_all_satisfied          (in_all_satisfied),
        .in_random                 (in_random),
        .in_stochastic_probability (in_stochastic_probability),
        .out_current_state         (out_current_state),
        .out_iteration_count       (out_iteration_count),
        .out_solved                (out_solved),
        .out_iteration_limit       (out_iteration_limit),
        .out_watchdog_error        (out_watchdog_error),
        .out_finish                (out_finish)
    );

    // ---------------- clock / reset ----------------
    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end within the time limit");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;
    logic [7:0]   prev_state = 8'd0;
    logic [W-1:0] mon_e;

    // Reference model of the solver outcome, in plain integers.
    int m_phase = 0;
    int m_count = 0;
    bit m_solved = 1'b0;
    bit m_limit  = 1'b0;
    bit m_wd     = 1'b0;

    function automatic logic [W-1:0] pack(int c, int ph, int cnt, bit s, bit l, bit w);
        logic [31:0] c32;
        logic [7:0]  p8;
        logic [15:0] n16;
        c32 = c;
        p8  = ph[7:0];
        n16 = cnt[15:0];
        return {c32, p8, n16, s, l, w};
    endfunction

    task automatic expect_at(int c);
        exp_q.push_back(pack(c, m_phase, m_count, m_solved, m_limit, m_wd));
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every phase change must match the next predicted record.
    always @(negedge in_clk) begin
        if (mon_en) begin
            if (out_current_state !== prev_state) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_transition: phase %0d -> %0d at cycle %0d, none expected",
                             prev_state, out_current_state, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("transition", {cyc[31:0], out_current_state, out_iteration_count,
                                         out_solved, out_iteration_limit, out_watchdog_error}, mon_e);
                    check("finish_flag", out_finish, (mon_e[26:19] == 8'd6));
                end
            end else if (exp_q.size() > 0 && exp_q[0][58:27] == cyc[31:0]) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                $display("FAIL missing_transition: phase stayed %0d at cycle %0d, expected phase %0d",
                         out_current_state, cyc, mon_e[26:19]);
            end
        end
        prev_state = out_current_state;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge in_clk);
    endtask

    task automatic clear_hs();
        in_setup_done          = 1'b0;
        in_probabilistic_ready = 1'b0;
        in_stochastic_ready    = 1'b0;
        in_adjust_done         = 1'b0;
        in_checker_done        = 1'b0;
        in_all_satisfied       = 1'b0;
    endtask

    task automatic drive_hs(int ph, logic v);
        case (ph)
            1: in_setup_done          = v;
            2: in_probabilistic_ready = v;
            3: in_stochastic_ready    = v;
            4: in_adjust_done         = v;
            5: in_checker_done        = v;
            default: ;
        endcase
    endtask

    // Random activity on every handshake the current phase does not wait for.
    task automatic noise(int ph);
        in_setup_done          = 1'($urandom_range(0, 1));
        in_probabilistic_ready = 1'($urandom_range(0, 1));
        in_stochastic_ready    = 1'($urandom_range(0, 1));
        in_adjust_done         = 1'($urandom_range(0, 1));
        in_checker_done        = 1'($urandom_range(0, 1));
        in_all_satisfied       = 1'($urandom_range(0, 1));
        drive_hs(ph, 1'b0);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_phase"},  out_current_state, 8'd0);
        check({tag, "_count"},  out_iteration_count, 16'd0);
        check({tag, "_solved"}, out_solved, 1'b0);
        check({tag, "_limit"},  out_iteration_limit, 1'b0);
        check({tag, "_wd"},     out_watchdog_error, 1'b0);
        check({tag, "_finish"}, out_finish, 1'b0);
    endtask

    // Called at the entry negedge of IDLE or FINISH; ends at SETUP entry.
    task automatic start_solve();
        if (in_start) begin
            in_start = 1'b0;
            tick();
        end
        in_start = 1'b1;
        m_phase = 1; m_count = 0; m_solved = 0; m_limit = 0; m_wd = 0;
        expect_at(cyc + 1);
        tick();
        in_start = 1'b0;
    endtask

    // Called at the entry negedge of a waiting phase: fire its handshake k
    // cycles later and end at the entry negedge of the next phase.
    task automatic do_phase(int k, bit sat, logic [7:0] rnd, logic [7:0] prob);
        int ph;
        ph = m_phase;
        noise(ph);
        for (int i = 0; i < k; i++) begin
            tick();
            noise(ph);
        end
        drive_hs(ph, 1'b1);
        if (ph == 5) begin
            in_all_satisfied          = sat;
            in_random                 = rnd;
            in_stochastic_probability = prob;
            if (sat) begin
                m_phase = 6; m_solved = 1;
            end else if (m_count == MAX_IT) begin
                m_phase = 6; m_limit = 1;
            end else begin
                m_count = m_count + 1;
                m_phase = (int'(rnd) < int'(prob)) ? 3 : 2;
            end
        end else if (ph == 1 || ph == 4) begin
            m_phase = 5;
        end else begin
            m_phase = 4;
        end
        expect_at(cyc + 1);
        tick();
        clear_hs();
    endtask

    task automatic run_to_finish(bit allow_sat);
        bit sat;
        while (m_phase != 6) begin
            sat = allow_sat && (m_phase == 5) && ($urandom_range(0, 3) == 0);
            do_phase($urandom_range(1, 6), sat, 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic hold_finish(int n);
        for (int i = 0; i < n; i++) begin
            noise(6);
            in_random = 8'($urandom);
            tick();
        end
        clear_hs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        in_reset = 1'b1;
        in_start = 1'b0;
        clear_hs();
        in_random = 8'd0;
        in_stochastic_probability = 8'd0;
        repeat (3) tick();
        in_reset = 1'b0;
        tick();
        mon_en = 1'b1;
        check_idle("reset");

        // Immediate solve: 0 -> 1 -> 5 -> 6 with solved, count 0.
        start_solve();
        do_phase(3, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b1, 8'd0, 8'd0);
        hold_finish(5);

        // Branch selection: 50 < 128 -> stochastic, 200 >= 128 -> probabilistic.
        start_solve();
        do_phase(2, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b0, 8'd50, 8'd128);
        do_phase(2, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b0, 8'd0, 8'd0);
        do_phase(2, 1'b0, 8'd200, 8'd128);
        do_phase(1, 1'b0, 8'd0, 8'd0);
        do_phase(3, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b1, 8'd0, 8'd0);
        hold_finish(3);

        // Stale stochastic ready on entry, then run to the iteration limit.
        start_solve();
        do_phase(1, 1'b0, 8'd0, 8'd0);
        in_stochastic_ready = 1'b1;
        do_phase(1, 1'b0, 8'd10, 8'd200);
        in_stochastic_ready = 1'b1;
        m_phase = 4;
        expect_at(cyc + 2);
        tick();
        tick();
        clear_hs();
        run_to_finish(1'b0);
        hold_finish(4);

        // Watchdog: adjust_done never comes, FINISH after 16 cycles in phase 4.
        start_solve();
        do_phase(2, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b0, 8'($urandom), 8'($urandom));
        do_phase(2, 1'b0, 8'd0, 8'd0);
        m_phase = 6; m_wd = 1;
        expect_at(cyc + TMO);
        for (int i = 0; i < TMO; i++) begin
            noise(4);
            tick();
        end
        clear_hs();
        hold_finish(3);

        // Same run with adjust_done on the last cycle: handshake wins.
        start_solve();
        do_phase(1, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b0, 8'($urandom), 8'($urandom));
        do_phase(1, 1'b0, 8'd0, 8'd0);
        do_phase(TMO - 1, 1'b0, 8'd0, 8'd0);
        do_phase(2, 1'b1, 8'd0, 8'd0);
        hold_finish(2);

        // Random solves.
        for (int s = 0; s < 6; s++) begin
            start_solve();
            run_to_finish(1'b1);
            hold_finish($urandom_range(1, 4));
        end

        // Reset in phase 3 with start held high; no restart until it toggles.
        start_solve();
        do_phase(1, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b0, 8'd5, 8'd100);
        tick();
        in_start = 1'b1;
        in_reset = 1'b1;
        m_phase = 0; m_count = 0; m_solved = 0; m_limit = 0; m_wd = 0;
        expect_at(cyc + 1);
        tick();
        in_reset = 1'b0;
        repeat (6) tick();
        check_idle("after_reset");
        start_solve();
        do_phase(2, 1'b0, 8'd0, 8'd0);
        do_phase(1, 1'b1, 8'd0, 8'd0);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
